reg_context_sequencer: RTL and testbench
========================================

// Module: reg_context_sequencer
// PURPOSE
//  Multi-cycle sequencer that saves (push) or restores (pop) registers R0..R(NUM_REGS-1)
//  through the register bank's stack, for interrupt/exception entry and return.
//  Drives the bank's RegD/control/enable/SPin/PCin and a word-addressed memory request port.
//  Sits beside the control unit; the control unit yields bank control while busy=1.
// PARAMETERS
//  NUM_REGS  13  registers transferred, R0..R(NUM_REGS-1); legal range 1..14 (R14/R15 never written)
//  WIDTH     32  data, address and SP width
// PORTS
//  clock          in   1      rising-edge clock
//  reset          in   1      asynchronous, active-high reset
//  start_save     in   1      1-cycle request: push registers
//  start_restore  in   1      1-cycle request: pop registers
//  sp_in          in   WIDTH  current bank SP (mode-selected); sampled at start
//  pc_in          in   WIDTH  current bank PC; passed to bank_pc_out unchanged
//  bank_mem_out   in   WIDTH  bank MemOut (value of Bank[reg_d])
//  mem_ready      in   1      memory accepted write / returned read data this cycle
//  mem_rdata      in   WIDTH  memory read data, valid when mem_ready=1
//  reg_d          out  4      bank RegD select
//  bank_control   out  3      bank control code: 0 = no reg write, 3 = RD<=MemIn
//  bank_enable    out  1      bank write enable (commit pulse)
//  bank_sp_out    out  WIDTH  bank SPin
//  bank_pc_out    out  WIDTH  bank PCin (= pc_in, PC held)
//  bank_mem_in    out  WIDTH  bank MemIn (captured restore data)
//  mem_req        out  1      memory request
//  mem_we         out  1      1 = write, 0 = read
//  mem_addr       out  WIDTH  word address
//  mem_wdata      out  WIDTH  write data (= bank_mem_out)
//  busy           out  1      sequencer owns the bank
//  done           out  1      1-cycle completion pulse
// BEHAVIOUR
//  Reset: state=IDLE; all registered outputs 0 (reg_d=0, bank_control=0, bank_enable=0,
//   mem_req=0, mem_we=0, busy=0, done=0, sp copy=0). Reset mid-operation abandons the
//   transfer immediately, drops mem_req; no bank commit occurs in that cycle.
//  States: IDLE, SAVE_REQ, SAVE_COMMIT, REST_REQ, REST_COMMIT, DONE.
//  IDLE: start_save -> SAVE_REQ, sp<=sp_in, idx<=NUM_REGS-1. Else start_restore -> REST_REQ,
//   sp<=sp_in, idx<=0. Both high: save wins, restore dropped. Starts outside IDLE ignored.
//  SAVE_REQ: reg_d=idx, mem_req=1, mem_we=1, mem_addr=sp-1, mem_wdata=bank_mem_out.
//   Held stable until mem_ready=1 is sampled; then -> SAVE_COMMIT.
//  SAVE_COMMIT: bank_enable=1, bank_control=0, bank_sp_out=sp-1, sp<=sp-1, mem_req=0.
//   idx==0 -> DONE, else idx<=idx-1 -> SAVE_REQ.
//  REST_REQ: mem_req=1, mem_we=0, mem_addr=sp; on mem_ready=1 capture mem_rdata -> REST_COMMIT.
//  REST_COMMIT: bank_enable=1, bank_control=3, reg_d=idx, bank_mem_in=captured,
//   bank_sp_out=sp+1, sp<=sp+1. idx==NUM_REGS-1 -> DONE, else idx<=idx+1 -> REST_REQ.
//  DONE: done=1, busy=1 for one cycle -> IDLE.
//  busy=1 in every state except IDLE. bank_enable=0 outside COMMIT states.
//  Memory image: R0 at lowest address; save then restore of same N returns SP to start value.
//  Arithmetic: sp +/-1 modulo 2^WIDTH; wrap-around is silent, no fault.
//  Latency (mem_ready tied 1): 2*NUM_REGS cycles busy + 1 DONE cycle after start edge.
//  mem_ready outside a REQ state is ignored.
// TESTING
//  1 Save, N=13, sp_in=0xFFFFFFFF, ready=1: writes R12@0xFFFFFFFE .. R0@0xFFFFFFF2;
//    final bank_sp_out=0xFFFFFFF2; done at cycle 27; 13 enable pulses with control=0.
//  2 Restore after test 1, ready delayed 3 cycles per access: R0..R12 restored in order,
//    control=3 on each commit, final SP=0xFFFFFFFF, req/addr stable while waiting.
//  3 start_save and start_restore same cycle -> save performed; restore never runs.
//  4 start_restore pulsed while busy in save -> ignored; only one done pulse.
//  5 Reset asserted during SAVE_REQ of idx=7 -> outputs all 0 same cycle, IDLE after release,
//    no further mem_req or bank_enable.
//  6 Restore N=2 from sp_in=0xFFFFFFFE -> reads 0xFFFFFFFE, 0xFFFFFFFF; final SP=0x00000000.

Source files
------------

// File: rtl/reg_context_sequencer.sv
// Register-bank context sequencer: pushes or pops R0..R(NUM_REGS-1) through the bank stack
// using a word-addressed memory port, one request/commit pair per register.
module reg_context_sequencer #(
    parameter int NUM_REGS = 13,
    parameter int WIDTH    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_save,
    input  logic             start_restore,
    input  logic [WIDTH-1:0] sp_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] bank_mem_out,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [3:0]       reg_d,
    output logic [2:0]       bank_control,
    output logic             bank_enable,
    output logic [WIDTH-1:0] bank_sp_out,
    output logic [WIDTH-1:0] bank_pc_out,
    output logic [WIDTH-1:0] bank_mem_in,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] SAVE_REQ    = 3'd1;
    localparam logic [2:0] SAVE_COMMIT = 3'd2;
    localparam logic [2:0] REST_REQ    = 3'd3;
    localparam logic [2:0] REST_COMMIT = 3'd4;
    localparam logic [2:0] DONE        = 3'd5;

    localparam logic [3:0] LAST_IDX    = 4'(NUM_REGS - 1);
    localparam logic [2:0] CTRL_NONE   = 3'd0;
    localparam logic [2:0] CTRL_MEMIN  = 3'd3;

    logic [2:0]       state_reg, state_next;
    logic [3:0]       idx_reg, idx_next;
    logic [WIDTH-1:0] sp_reg, sp_next;
    logic [WIDTH-1:0] capt_reg, capt_next;
    logic [WIDTH-1:0] sp_dec, sp_inc;

    // Stack grows downward; both directions wrap silently modulo 2^WIDTH.
    assign sp_dec = sp_reg - WIDTH'(1);
    assign sp_inc = sp_reg + WIDTH'(1);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        sp_next    = sp_reg;
        capt_next  = capt_reg;
        case (state_reg)
            IDLE: begin
                if (start_save) begin
                    state_next = SAVE_REQ;
                    sp_next    = sp_in;
                    idx_next   = LAST_IDX;
                end else if (start_restore) begin
                    state_next = REST_REQ;
                    sp_next    = sp_in;
                    idx_next   = 4'd0;
                end
            end
            SAVE_REQ: begin
                if (mem_ready) begin
                    state_next = SAVE_COMMIT;
                end
            end
            SAVE_COMMIT: begin
                sp_next = sp_dec;
                if (idx_reg == 4'd0) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg - 4'd1;
                    state_next = SAVE_REQ;
                end
            end
            REST_REQ: begin
                if (mem_ready) begin
                    capt_next  = mem_rdata;
                    state_next = REST_COMMIT;
                end
            end
            REST_COMMIT: begin
                sp_next = sp_inc;
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + 4'd1;
                    state_next = REST_REQ;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= 4'd0;
            sp_reg    <= '0;
            capt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            sp_reg    <= sp_next;
            capt_reg  <= capt_next;
        end
    end

    // Outputs decode directly from state so an asynchronous reset clears them at once.
    always_comb begin
        reg_d        = 4'd0;
        bank_control = CTRL_NONE;
        bank_enable  = 1'b0;
        bank_sp_out  = sp_reg;
        bank_pc_out  = pc_in;
        bank_mem_in  = capt_reg;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = bank_mem_out;
        busy         = (state_reg != IDLE);
        done         = (state_reg == DONE);
        case (state_reg)
            SAVE_REQ: begin
                reg_d    = idx_reg;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = sp_dec;
            end
            SAVE_COMMIT: begin
                reg_d       = idx_reg;
                bank_enable = 1'b1;
                bank_sp_out = sp_dec;
            end
            REST_REQ: begin
                reg_d    = idx_reg;
                mem_req  = 1'b1;
                mem_addr = sp_reg;
            end
            REST_COMMIT: begin
                reg_d        = idx_reg;
                bank_enable  = 1'b1;
                bank_control = CTRL_MEMIN;
                bank_sp_out  = sp_inc;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_reg_context_sequencer.sv
// Bench for reg_context_sequencer: bank/memory environment plus a transaction-queue model
// of the pushes, pops and commits each operation must produce.
module tb_reg_context_sequencer;

    localparam int N = 13;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        logic [3:0]  rd;
        logic [2:0]  ctrl;
        logic [31:0] data;
        logic [31:0] sp;
    } cmt_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_save = 1'b0;
    logic        start_restore = 1'b0;
    logic [31:0] sp_in = 32'h0;
    logic [31:0] pc_in = 32'h1234_5678;
    logic [31:0] bank_mem_out;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata;
    logic [3:0]  reg_d;
    logic [2:0]  bank_control;
    logic        bank_enable;
    logic [31:0] bank_sp_out;
    logic [31:0] bank_pc_out;
    logic [31:0] bank_mem_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;

    reg_context_sequencer #(.NUM_REGS(N), .WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start_save(start_save), .start_restore(start_restore),
        .sp_in(sp_in), .pc_in(pc_in), .bank_mem_out(bank_mem_out), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .reg_d(reg_d), .bank_control(bank_control),
        .bank_enable(bank_enable), .bank_sp_out(bank_sp_out), .bank_pc_out(bank_pc_out),
        .bank_mem_in(bank_mem_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Environment: register bank and a 256-word memory indexed by the low address byte.
    logic [31:0] bank [16];
    logic [31:0] mem [256];
    logic [31:0] bank_sp = 32'h0;
    assign bank_mem_out = bank[reg_d];
    assign mem_rdata    = mem[mem_addr[7:0]];

    acc_t exp_wr[$];
    logic [31:0] exp_rd[$];
    cmt_t exp_cmt[$];

    int passed = 0;
    int total = 0;
    int done_count = 0;
    int cmt_count = 0;
    int mode = 0;
    int wait_cnt = 0;

    acc_t        m_wr;
    logic [31:0] m_rd;
    cmt_t        m_cmt;
    logic        m_acc;
    logic        prev_req = 1'b0;
    logic        prev_acc = 1'b0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] prev_wdata = 32'h0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endfunction

    // Per-cycle monitor: decide mem_ready for the coming edge, then score accepted
    // accesses and bank commits against the expected transaction queues.
    always @(negedge clock) begin
        if (reset) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
            prev_req  = 1'b0;
        end else begin
            case (mode)
                0: mem_ready = 1'b1;
                1: begin
                    if (mem_req) begin
                        if (wait_cnt == 3) begin
                            mem_ready = 1'b1;
                            wait_cnt  = 0;
                        end else begin
                            mem_ready = 1'b0;
                            wait_cnt++;
                        end
                    end else begin
                        mem_ready = 1'b0;
                        wait_cnt  = 0;
                    end
                end
                default: mem_ready = 1'($urandom_range(0, 1));
            endcase
            m_acc = mem_req && mem_ready;
            check("pc_passthru", bank_pc_out, pc_in);
            if (prev_req && !prev_acc && mem_req) begin
                check("stable_addr", mem_addr, prev_addr);
                check("stable_we", 32'(mem_we), 32'(prev_we));
                check("stable_wdata", mem_wdata, prev_wdata);
            end
            if (m_acc) begin
                if (mem_we) begin
                    check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
                    if (exp_wr.size() != 0) begin
                        m_wr = exp_wr.pop_front();
                        check("wr_addr", mem_addr, m_wr.addr);
                        check("wr_data", mem_wdata, m_wr.data);
                    end
                    mem[mem_addr[7:0]] = mem_wdata;
                end else begin
                    check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
                    if (exp_rd.size() != 0) begin
                        m_rd = exp_rd.pop_front();
                        check("rd_addr", mem_addr, m_rd);
                    end
                end
            end
            if (bank_enable) begin
                cmt_count++;
                check("cmt_no_req", 32'(mem_req), 32'd0);
                check("cmt_expected", 32'(exp_cmt.size() != 0), 32'd1);
                if (exp_cmt.size() != 0) begin
                    m_cmt = exp_cmt.pop_front();
                    check("cmt_ctrl", 32'(bank_control), 32'(m_cmt.ctrl));
                    check("cmt_sp", bank_sp_out, m_cmt.sp);
                    if (m_cmt.ctrl == 3'd3) begin
                        check("cmt_reg", 32'(reg_d), 32'(m_cmt.rd));
                        check("cmt_data", bank_mem_in, m_cmt.data);
                    end
                end
                if (bank_control == 3'd3) bank[reg_d] = bank_mem_in;
                bank_sp = bank_sp_out;
            end
            if (done) begin
                done_count++;
                check("done_queues_empty", 32'(exp_wr.size() + exp_rd.size() + exp_cmt.size()), 32'd0);
                check("done_busy", 32'(busy), 32'd1);
            end
            prev_req   = mem_req;
            prev_acc   = m_acc;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    task automatic build_queues(input bit do_save, input bit do_rest, input logic [31:0] sp0,
                                output logic [31:0] final_sp);
        acc_t wa;
        cmt_t ca;
        logic [31:0] a;
        final_sp = sp0;
        if (do_save) begin
            for (int k = 0; k < N; k++) begin
                a       = sp0 - 32'(k) - 32'd1;
                wa.addr = a;
                wa.data = bank[N - 1 - k];
                exp_wr.push_back(wa);
                ca.rd   = 4'(N - 1 - k);
                ca.ctrl = 3'd0;
                ca.data = 32'h0;
                ca.sp   = a;
                exp_cmt.push_back(ca);
            end
            final_sp = sp0 - 32'(N);
        end else if (do_rest) begin
            for (int k = 0; k < N; k++) begin
                a = sp0 + 32'(k);
                exp_rd.push_back(a);
                ca.rd   = 4'(k);
                ca.ctrl = 3'd3;
                ca.data = mem[a[7:0]];
                ca.sp   = a + 32'd1;
                exp_cmt.push_back(ca);
            end
            final_sp = sp0 + 32'(N);
        end
    endtask

    task automatic flush_queues();
        exp_wr.delete();
        exp_rd.delete();
        exp_cmt.delete();
    endtask

    task automatic run_op(input bit do_save, input bit do_rest, input logic [31:0] sp0,
                          input int exp_lat, input int inject_at, input string tag);
        int cyc;
        bit seen;
        int dc0;
        int cc0;
        logic [31:0] final_sp;
        @(negedge clock);
        dc0 = done_count;
        cc0 = cmt_count;
        build_queues(do_save, do_rest, sp0, final_sp);
        start_save    = do_save;
        start_restore = do_rest;
        sp_in         = sp0;
        @(posedge clock);
        #1;
        start_save    = 1'b0;
        start_restore = 1'b0;
        sp_in         = $urandom;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 600) begin
            @(negedge clock);
            cyc++;
            if (cyc == inject_at) start_restore = 1'b1;
            else if (cyc == inject_at + 1) start_restore = 1'b0;
            if (done) seen = 1'b1;
        end
        start_restore = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (exp_lat > 0) check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        repeat (4) @(negedge clock);
        if (!seen) flush_queues();
        check({tag, "_done_pulses"}, 32'(done_count - dc0), 32'd1);
        check({tag, "_commits"}, 32'(cmt_count - cc0), 32'(N));
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_final_sp"}, bank_sp, final_sp);
        $display("op %s save=%0d restore=%0d sp0=%h cycles=%0d final_sp=%h", tag, do_save, do_rest,
                 sp0, cyc, bank_sp);
    endtask

    initial begin
        logic [31:0] fsp;
        int act;
        bit found;
        bit sv;

        for (int i = 0; i < 16; i++) bank[i] = 32'hA5A5_0000 + 32'(i);
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        // Reset state
        @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_en", 32'(bank_enable), 32'd0);
        check("rst_ctrl", 32'(bank_control), 32'd0);
        check("rst_regd", 32'(reg_d), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sp", bank_sp_out, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 1: save from top of address space, ready tied high
        mode = 0;
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 27, -1, "t1_save");
        check("t1_pin_r12", mem[8'hFE], 32'hA5A5_000C);
        check("t1_pin_r0", mem[8'hF2], 32'hA5A5_0000);
        check("t1_pin_sp", bank_sp, 32'hFFFF_FFF2);

        // 2: restore with 3-cycle memory delay after clobbering the bank
        for (int i = 0; i < N; i++) bank[i] = $urandom;
        mode = 1;
        run_op(1'b0, 1'b1, 32'hFFFF_FFF2, -1, -1, "t2_rest");
        check("t2_pin_r0", bank[0], 32'hA5A5_0000);
        check("t2_pin_r12", bank[12], 32'hA5A5_000C);
        check("t2_pin_sp", bank_sp, 32'hFFFF_FFFF);

        // 3: simultaneous starts -> save only
        mode = 0;
        run_op(1'b1, 1'b1, 32'h0000_0100, 27, -1, "t3_both");
        check("t3_pin_sp", bank_sp, 32'h0000_00F3);

        // 4: restore request while busy is ignored
        run_op(1'b1, 1'b0, 32'h0000_8000, 27, 5, "t4_inject");
        check("t4_pin_sp", bank_sp, 32'h0000_7FF3);

        // 5: reset during SAVE_REQ of R7
        @(negedge clock);
        build_queues(1'b1, 1'b0, 32'h0000_0400, fsp);
        start_save = 1'b1;
        sp_in      = 32'h0000_0400;
        @(posedge clock);
        #1;
        start_save = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (mem_req && reg_d == 4'd7) found = 1'b1;
        end
        check("t5_reached_r7", 32'(found), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_req", 32'(mem_req), 32'd0);
        check("t5_we", 32'(mem_we), 32'd0);
        check("t5_en", 32'(bank_enable), 32'd0);
        check("t5_ctrl", 32'(bank_control), 32'd0);
        check("t5_regd", 32'(reg_d), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_addr", mem_addr, 32'h0);
        flush_queues();
        @(negedge clock);
        reset = 1'b0;
        act = 0;
        repeat (12) begin
            @(negedge clock);
            act += int'(mem_req) + int'(bank_enable) + int'(busy);
        end
        check("t5_quiet", 32'(act), 32'd0);
        $display("op t5_reset found=%0d activity_after=%0d", found, act);

        // 6: wrap-around in both directions
        mode = 2;
        run_op(1'b0, 1'b1, 32'hFFFF_FFFA, -1, -1, "t6_rest_wrap");
        check("t6_pin_sp", bank_sp, 32'h0000_0007);
        check("t6_pin_r0", bank[0], mem[8'hFA]);
        check("t6_pin_r6", bank[6], mem[8'h00]);
        run_op(1'b1, 1'b0, 32'h0000_0005, -1, -1, "t6_save_wrap");
        check("t6_pin_sp2", bank_sp, 32'hFFFF_FFF8);

        // Random operations
        for (int t = 0; t < 8; t++) begin
            mode = $urandom_range(0, 2);
            sv = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) bank[i] = $urandom;
            run_op(sv, !sv, $urandom, -1, -1, "rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
